// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: FSM states, reset coefficient and a
// constant-function clog2 for sizing the tap index.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int COEF_RESET = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/go_edge_det.sv
// Rising-edge detector for the debounced go button: a held level yields a single pulse.
module go_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic go_rise
);

  logic go_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go;
    end
  end

  assign go_rise = go & ~go_q;

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one multiply-accumulate per clock over TAPS run-time loadable
// coefficients. Define FIR_SAT_EN to clip y at all ones (flagging y_sat) instead of wrapping.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int COEF_W = 8,
  parameter  int TAPS   = 4,
  parameter  int OUT_W  = 16,
  localparam int IDX_W  = clog2(TAPS),
  localparam int ACC_W  = DATA_W + COEF_W + IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] in,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_din,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              y_sat,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t              state_q, state_d;
  logic                goEdge;
  logic                capture;
  logic                coefWrite;
  logic [DATA_W-1:0]   x_q [TAPS];
  logic [COEF_W-1:0]   c_q [TAPS];
  logic [PROD_W-1:0]   prod;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [OUT_W-1:0]    y_q, y_d;
  logic                yValid_q;
  logic                ySat_q, ySat_d;

  go_edge_det uGoEdge (
    .clk     (clk),
    .rst     (rst),
    .go      (go),
    .go_rise (goEdge)
  );

  assign prod      = PROD_W'(x_q[idx_q]) * PROD_W'(c_q[idx_q]);
  assign coefWrite = (state_q == ST_IDLE) && coef_we && (int'(coef_addr) < TAPS);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (goEdge) begin
          capture = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef FIR_SAT_EN
  always_comb begin
    y_d    = OUT_W'(acc_q);
    ySat_d = 1'b0;
    if ((acc_q >> OUT_W) != '0) begin
      y_d    = '1;
      ySat_d = 1'b1;
    end
  end
`else
  assign y_d    = OUT_W'(acc_q);
  assign ySat_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      y_q      <= '0;
      yValid_q <= 1'b0;
      ySat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      yValid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        y_q    <= y_d;
        ySat_q <= ySat_d;
      end
    end
  end

  // A coefficient written in the same cycle as a capture is already in place for the first MAC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= COEF_W'(COEF_RESET);
      end
    end else begin
      if (capture) begin
        x_q[0] <= in;
        for (int k = 1; k < TAPS; k++) begin
          x_q[k] <= x_q[k-1];
        end
      end
      if (coefWrite) begin
        c_q[coef_addr] <= coef_din;
      end
    end
  end

  assign y       = y_q;
  assign y_valid = yValid_q;
  assign y_sat   = ySat_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
